// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: main control FSM of the multi-cycle MIPS core, arbitrating one memory port.
// Define MC_CTRL_PERF_EN to add cycle/instruction/stall performance counters.
module mips_mc_ctrl
`ifdef MC_CTRL_PERF_EN
#(
    parameter int unsigned PERF_W = 32
)
`endif
(
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        op,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              iord,
    output logic              mem_write,
    output logic              ir_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              reg_write,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        alu_op,
    output logic [1:0]        pc_src,
    output logic              pc_en,
    output logic              illegal_op,
`ifdef MC_CTRL_PERF_EN
    output logic [PERF_W-1:0] cyc_cnt,
    output logic [PERF_W-1:0] instr_cnt,
    output logic [PERF_W-1:0] stall_cnt,
`endif
    output logic [3:0]        state
);

    localparam int unsigned ST_W = 4;
    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    typedef enum logic [ST_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_pc_write;
    logic   w_pc_write_cond;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control decode; reset masks every control so an aborted
    // instruction cannot write the register file, memory or PC.
    always_comb begin
        w_next_state    = S_FETCH;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        mem_req         = 1'b0;
        iord            = 1'b0;
        mem_write       = 1'b0;
        ir_write        = 1'b0;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        reg_write       = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        alu_op          = 2'b00;
        pc_src          = 2'b00;
        illegal_op      = 1'b0;
        pc_en           = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_req      = 1'b1;
                alu_src_b    = 2'b01;
                ir_write     = mem_ready;
                w_pc_write   = mem_ready;
                w_next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXEC;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JUMP;
                    default: begin
                        w_next_state = S_FETCH;
                        illegal_op   = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                w_next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req      = 1'b1;
                iord         = 1'b1;
                w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write    = 1'b1;
                mem_to_reg   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                mem_req      = 1'b1;
                iord         = 1'b1;
                mem_write    = 1'b1;
                w_next_state = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a    = 1'b1;
                alu_op       = 2'b10;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write    = 1'b1;
                reg_dst      = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = 2'b01;
                pc_src          = 2'b01;
                w_pc_write_cond = 1'b1;
                w_next_state    = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                w_next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src       = 2'b10;
                w_pc_write   = 1'b1;
                w_next_state = S_FETCH;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase

        pc_en = w_pc_write | (w_pc_write_cond & zero);

        if (rst) begin
            mem_req    = 1'b0;
            iord       = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            pc_src     = 2'b00;
            illegal_op = 1'b0;
            pc_en      = 1'b0;
        end
    end

    assign state = r_state;

`ifdef MC_CTRL_PERF_EN
    logic [PERF_W-1:0] r_cyc_cnt;
    logic [PERF_W-1:0] r_instr_cnt;
    logic [PERF_W-1:0] r_stall_cnt;

    // Free-running counters, wrapping naturally at 2^PERF_W
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_cnt   <= '0;
            r_instr_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_state != S_IDLE) begin
                r_cyc_cnt <= r_cyc_cnt + PERF_W'(1);
            end
            if (r_state == S_DECODE) begin
                r_instr_cnt <= r_instr_cnt + PERF_W'(1);
            end
            if (mem_req && !mem_ready) begin
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            end
        end
    end

    assign cyc_cnt   = r_cyc_cnt;
    assign instr_cnt = r_instr_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule
